// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the sync_fifo_buf staging buffer: default sizes, pointer width and parity helper.
// The optional stored-parity feature (SYNC_FIFO_PARITY_EN) uses even_parity below.
package sync_fifo_pkg;

    localparam int DEF_DATAWIDTH = 8;
    localparam int DEF_ASIZE     = 4;
    localparam int PAR_MAXW      = 64;

    // One extra wrap bit distinguishes full from empty when the low bits match.
    function automatic int ptr_width(input int asize);
        return asize + 1;
    endfunction

    // Zero padding does not change the XOR, so narrower words are zero-extended by the caller.
    function automatic logic even_parity(input logic [PAR_MAXW-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage for sync_fifo_buf: one write port, one enabled registered read port, no reset.
// Width is DATAWIDTH, or DATAWIDTH+1 when SYNC_FIFO_PARITY_EN stores a parity bit.
module sync_fifo_ram
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH = DEF_DATAWIDTH,
    parameter int ASIZE = DEF_ASIZE
) (
    input  logic             clk,
    input  logic             we,
    input  logic [ASIZE-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [ASIZE-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    localparam int DEPTH = 1 << ASIZE;

    logic [WIDTH-1:0] mem [0:DEPTH-1];
    logic [WIDTH-1:0] rdata_reg;

    // The read register only loads on a read, so the last word stays visible.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_reg <= mem[raddr];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/sync_fifo_buf.sv
// Single-clock FIFO with registered read data, occupancy count, threshold flags and sticky error flags.
// Define SYNC_FIFO_PARITY_EN to store an even-parity bit per word and report mismatches on parity_err.
module sync_fifo_buf
    import sync_fifo_pkg::*;
#(
    parameter int DATAWIDTH = DEF_DATAWIDTH,
    parameter int ASIZE     = DEF_ASIZE,
    parameter int DEEPTH    = 1 << ASIZE,
    parameter int AF_LEVEL  = DEEPTH - 2,
    parameter int AE_LEVEL  = 2
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 wen,
    input  logic [DATAWIDTH-1:0] wdata,
    input  logic                 ren,
    output logic [DATAWIDTH-1:0] rdata,
    output logic                 rvalid,
    input  logic                 flush,
    input  logic                 clr_err,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [ASIZE:0]       count,
    output logic                 overflow,
`ifdef SYNC_FIFO_PARITY_EN
    output logic                 parity_err,
`endif
    output logic                 underflow
);

    localparam int PW = ptr_width(ASIZE);
`ifdef SYNC_FIFO_PARITY_EN
    localparam int SW = DATAWIDTH + 1;
`else
    localparam int SW = DATAWIDTH;
`endif

    logic [PW-1:0] wptr_reg, rptr_reg;
    logic          rvalid_reg;
    logic          have_read_reg;
    logic          overflow_reg, underflow_reg;
    logic          wr_acc, rd_acc;
    logic [SW-1:0] ram_wdata, ram_q;

    // Occupancy comes from registered pointers only, so no flag depends on wen/ren this cycle.
    assign count        = wptr_reg - rptr_reg;
    assign full         = (count == PW'(DEEPTH));
    assign empty        = (count == '0);
    assign almost_full  = (count >= PW'(AF_LEVEL));
    assign almost_empty = (count <= PW'(AE_LEVEL));

    assign wr_acc = wen & ~full  & ~flush;
    assign rd_acc = ren & ~empty & ~flush;

`ifdef SYNC_FIFO_PARITY_EN
    logic parity_err_reg;
    logic parity_bad;

    assign ram_wdata  = {even_parity(PAR_MAXW'(wdata)), wdata};
    assign parity_bad = rvalid_reg &
                        (even_parity(PAR_MAXW'(ram_q[DATAWIDTH-1:0])) != ram_q[DATAWIDTH]);
    // The live term lets the flag rise in the same cycle as the offending word's rvalid.
    assign parity_err = parity_err_reg | parity_bad;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            parity_err_reg <= 1'b0;
        end else if (parity_bad) begin
            parity_err_reg <= 1'b1;
        end else if (clr_err) begin
            parity_err_reg <= 1'b0;
        end
    end
`else
    assign ram_wdata = wdata;
`endif

    sync_fifo_ram #(
        .WIDTH (SW),
        .ASIZE (ASIZE)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wptr_reg[ASIZE-1:0]),
        .wdata (ram_wdata),
        .re    (rd_acc),
        .raddr (rptr_reg[ASIZE-1:0]),
        .rdata (ram_q)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr_reg      <= '0;
            rptr_reg      <= '0;
            rvalid_reg    <= 1'b0;
            have_read_reg <= 1'b0;
        end else if (flush) begin
            wptr_reg   <= '0;
            rptr_reg   <= '0;
            rvalid_reg <= 1'b0;
        end else begin
            if (wr_acc) begin
                wptr_reg <= wptr_reg + PW'(1);
            end
            if (rd_acc) begin
                rptr_reg      <= rptr_reg + PW'(1);
                have_read_reg <= 1'b1;
            end
            rvalid_reg <= rd_acc;
        end
    end

    // Dropped requests during flush leave the sticky flags exactly as they were.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else if (!flush) begin
            overflow_reg  <= (wen & full)  | (overflow_reg  & ~clr_err);
            underflow_reg <= (ren & empty) | (underflow_reg & ~clr_err);
        end
    end

    // The storage has no reset, so rdata reads as zero until the first accepted read.
    assign rdata     = have_read_reg ? ram_q[DATAWIDTH-1:0] : '0;
    assign rvalid    = rvalid_reg;
    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;

endmodule

// File: tb/tb_sync_fifo_buf.sv
// Directed self-checking bench for sync_fifo_buf (DATAWIDTH=8, ASIZE=4, DEEPTH=16).
// Parity corruption steps are only built when SYNC_FIFO_PARITY_EN is defined.
module tb_sync_fifo_buf;

    logic       clk = 1'b0;
    logic       resetn;
    logic       wen, ren, flush, clr_err;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       rvalid, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [4:0] count;
`ifdef SYNC_FIFO_PARITY_EN
    logic       parity_err;
    logic [8:0] tmp_word;
`endif

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    sync_fifo_buf dut (
        .clk          (clk),
        .resetn       (resetn),
        .wen          (wen),
        .wdata        (wdata),
        .ren          (ren),
        .rdata        (rdata),
        .rvalid       (rvalid),
        .flush        (flush),
        .clr_err      (clr_err),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
`ifdef SYNC_FIFO_PARITY_EN
        .parity_err   (parity_err),
`endif
        .underflow    (underflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn = 1'b0; wen = 1'b0; ren = 1'b0; flush = 1'b0; clr_err = 1'b0; wdata = 8'h00;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        step();
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_aempty", 32'(almost_empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_afull", 32'(almost_full), 0);
        chk("rst_rvalid", 32'(rvalid), 0);
        chk("rst_rdata", 32'(rdata), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_udf", 32'(underflow), 0);

        // Fill 0x00..0x0F
        for (int i = 0; i < 16; i++) begin
            wen = 1'b1; wdata = 8'(i);
            step();
            chk("fill_count", 32'(count), 32'(i + 1));
            chk("fill_afull", 32'(almost_full), 32'((i + 1) >= 14));
            chk("fill_full", 32'(full), 32'((i + 1) == 16));
            chk("fill_aempty", 32'(almost_empty), 32'((i + 1) <= 2));
            chk("fill_empty", 32'(empty), 0);
        end
        wdata = 8'hAA;
        step();
        wen = 1'b0;
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_count", 32'(count), 16);

        // Drain with a gap after each read so rvalid is seen as a pulse
        for (int i = 0; i < 16; i++) begin
            ren = 1'b1;
            step();
            ren = 1'b0;
            chk("drain_rvalid", 32'(rvalid), 1);
            chk("drain_rdata", 32'(rdata), 32'(i));
            chk("drain_count", 32'(count), 32'(15 - i));
`ifdef SYNC_FIFO_PARITY_EN
            chk("drain_perr", 32'(parity_err), 0);
`endif
            step();
            chk("drain_gap_rvalid", 32'(rvalid), 0);
            chk("drain_hold_rdata", 32'(rdata), 32'(i));
        end
        chk("drain_empty", 32'(empty), 1);
        ren = 1'b1;
        step();
        ren = 1'b0;
        chk("udf_flag", 32'(underflow), 1);
        chk("udf_rvalid", 32'(rvalid), 0);
        chk("udf_rdata_hold", 32'(rdata), 32'h0F);
        chk("udf_ovf_sticky", 32'(overflow), 1);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("clr_ovf", 32'(overflow), 0);
        chk("clr_udf", 32'(underflow), 0);

        // Streaming across pointer wrap
        wen = 1'b1; wdata = 8'h40;
        step();
        ren = 1'b1;
        for (int j = 0; j < 40; j++) begin
            wdata = 8'(8'h41 + j);
            step();
            chk("wrap_count", 32'(count), 1);
            chk("wrap_rvalid", 32'(rvalid), 1);
            chk("wrap_rdata", 32'(rdata), 32'(8'h40 + j));
        end
        wen = 1'b0;
        step();
        ren = 1'b0;
        chk("wrap_last", 32'(rdata), 32'h68);
        chk("wrap_empty", 32'(count), 0);

        // Simultaneous read/write when full
        for (int i = 0; i < 16; i++) begin
            wen = 1'b1; wdata = 8'(8'h80 + i);
            step();
        end
        chk("full2", 32'(full), 1);
        ren = 1'b1; wdata = 8'hEE;
        step();
        wen = 1'b0;
        chk("simf_count", 32'(count), 15);
        chk("simf_ovf", 32'(overflow), 1);
        chk("simf_rdata", 32'(rdata), 32'h80);
        for (int i = 0; i < 15; i++) begin
            step();
            chk("simf_drain", 32'(rdata), 32'(8'h81 + i));
        end
        ren = 1'b0;
        chk("simf_empty", 32'(empty), 1);

        // Simultaneous read/write when empty
        wen = 1'b1; ren = 1'b1; wdata = 8'h55;
        step();
        wen = 1'b0; ren = 1'b0;
        chk("sime_count", 32'(count), 1);
        chk("sime_udf", 32'(underflow), 1);
        chk("sime_rvalid", 32'(rvalid), 0);
        ren = 1'b1;
        step();
        ren = 1'b0;
        chk("sime_rdata", 32'(rdata), 32'h55);

        // clr_err loses against a coincident error event
        ren = 1'b1; clr_err = 1'b1;
        step();
        ren = 1'b0;
        chk("clr_vs_event", 32'(underflow), 1);
        chk("clr_other", 32'(overflow), 0);
        step();
        clr_err = 1'b0;
        chk("clr_udf2", 32'(underflow), 0);

        // Flush with count=9 and a write in the same cycle
        for (int i = 0; i < 9; i++) begin
            wen = 1'b1; wdata = 8'(8'h10 + i);
            step();
        end
        chk("pre_flush", 32'(count), 9);
        flush = 1'b1; wdata = 8'h77;
        step();
        wen = 1'b0;
        chk("flush_count", 32'(count), 0);
        chk("flush_empty", 32'(empty), 1);
        chk("flush_rdata", 32'(rdata), 32'h55);
        chk("flush_ovf", 32'(overflow), 0);
        ren = 1'b1;
        step();
        flush = 1'b0; ren = 1'b0;
        chk("flush_udf", 32'(underflow), 0);
        chk("flush_rvalid", 32'(rvalid), 0);
        wen = 1'b1; wdata = 8'h33;
        step();
        wen = 1'b0; ren = 1'b1;
        step();
        ren = 1'b0;
        chk("post_flush_rd", 32'(rdata), 32'h33);
        chk("post_flush_cnt", 32'(count), 0);

        // Asynchronous reset while a read is in flight
        wen = 1'b1; wdata = 8'h21;
        step();
        wdata = 8'h22;
        step();
        wen = 1'b0; ren = 1'b1;
        step();
        ren = 1'b0;
        chk("pre_arst_rvalid", 32'(rvalid), 1);
        #2 resetn = 1'b0;
        #1;
        chk("arst_count", 32'(count), 0);
        chk("arst_rvalid", 32'(rvalid), 0);
        chk("arst_rdata", 32'(rdata), 0);
        chk("arst_empty", 32'(empty), 1);
        @(negedge clk);
        resetn = 1'b1;

`ifdef SYNC_FIFO_PARITY_EN
        // Corrupt the stored parity bit of the word at address 0
        wen = 1'b1; wdata = 8'h5A;
        step();
        wen = 1'b0;
        tmp_word = dut.u_ram.mem[0];
        tmp_word[8] = ~tmp_word[8];
        dut.u_ram.mem[0] = tmp_word;
        ren = 1'b1;
        step();
        ren = 1'b0;
        chk("par_rvalid", 32'(rvalid), 1);
        chk("par_err", 32'(parity_err), 1);
        step();
        chk("par_sticky", 32'(parity_err), 1);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("par_clr", 32'(parity_err), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sync_fifo_buf.md
Name: sync_fifo_buf

Overview:
Parametrised single-clock FIFO: storage plus pointer/flag control in one block, with registered read data, occupancy count, programmable almost-full/almost-empty thresholds and sticky overflow/underflow error flags.
- Generalises the team's bare dual-port FIFO memory into a self-contained buffer.
- Used as the staging buffer between the QSPI shifter and the host-side register interface.

Parameters:
DATAWIDTH, 8, data word width in bits
ASIZE, 4, address bits; storage depth is DEEPTH words
DEEPTH, 1<<ASIZE, number of words; must be a power of two, at least 2
AF_LEVEL, DEEPTH-2, almost_full asserts when count >= AF_LEVEL (legal range 1..DEEPTH)
AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL (legal range 0..DEEPTH-1)

Ports:
clk  input  1  single clock; all logic on the rising edge
resetn  input  1  asynchronous active-low reset
wen  input  1  write request
wdata  input  DATAWIDTH  write data, sampled with wen
ren  input  1  read request
rdata  output  DATAWIDTH  registered read data; valid when rvalid=1
rvalid  output  1  one-cycle pulse, the cycle after an accepted read
flush  input  1  synchronous clear of contents
clr_err  input  1  clears sticky error flags
full  output  1  count == DEEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_LEVEL
almost_empty  output  1  count <= AE_LEVEL
count  output  ASIZE+1  current occupancy, 0..DEEPTH
overflow  output  1  sticky: write attempted while full
underflow  output  1  sticky: read attempted while empty

Behaviour:
- Reset: assertion is asynchronous, release is synchronous to clk. Reset values:
  - wptr = rptr = 0, count = 0
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0
  - rdata = 0, rvalid = 0, overflow = 0, underflow = 0
  - Memory array is not reset; its contents are undefined until written.
- Pointers: ASIZE+1 bits wide, with the extra MSB used as the wrap bit. Memory is indexed by the low ASIZE bits, so addressing wraps modulo DEEPTH.
- Write accept: wen=1 and full=0. The word is written at wptr[ASIZE-1:0] and wptr increments.
- Read accept: ren=1 and empty=0. mem[rptr] is registered into rdata, rptr increments, and rvalid=1 on the following cycle. Read latency is 1 cycle.
- rdata holds its last value when no read is accepted.
- Acceptance is judged on the flags at the start of the cycle:
  - Write while full is rejected even if a read is accepted in the same cycle.
  - Read while empty is rejected even if a write is accepted in the same cycle.
  - No write-to-read bypass.
- count update:
  - +1 on write-only accept
  - -1 on read-only accept
  - unchanged when both are accepted or neither is
- Flags are decoded from registered count only. There is no combinational path from wen/ren to any flag.
- Error flags:
  - overflow sets when wen=1 and full=1.
  - underflow sets when ren=1 and empty=1.
  - Both hold until clr_err=1.
  - If clr_err and a new error event occur in the same cycle, the event wins and the flag stays set.
- flush:
  - Next cycle: wptr = rptr = 0, count = 0, rvalid = 0.
  - Takes priority over wen/ren in the same cycle; those requests are dropped and raise no error flags.
  - rdata and the sticky flags are unchanged.
- Reset asserted mid-operation forces all reset values immediately. Any in-flight rvalid is lost.

Optional Feature:
Macro SYNC_FIFO_PARITY_EN.
- Defined:
  - Each stored word carries one extra even-parity bit, computed from wdata at write.
  - On every accepted read, parity is recomputed. A mismatch sets output parity_err, coincident with rvalid.
  - parity_err is sticky, cleared by clr_err, reset value 0.
  - Storage width becomes DATAWIDTH+1.
- Undefined: no parity bit stored, and the parity_err port is absent.

Decomposition:
- Shared package sync_fifo_pkg:
  - pointer/count width function clog2-style (ASIZE+1)
  - localparam defaults for DATAWIDTH/ASIZE
  - parity helper function
- Sub-module sync_fifo_ram: one write port and one registered read port, clock only, no reset. Width is DATAWIDTH or DATAWIDTH+1.
- sync_fifo_buf holds pointers, count, flags and error logic.

Test Plan:
- Reset then idle: count=0, empty=1, almost_empty=1, rvalid=0, rdata=0.
- Write 16 words 0x00..0x0F (DEEPTH=16): full=1, count=16, almost_full from count 14. A 17th write with 0xAA gives overflow=1, count stays 16, and a later read returns 0x00, not 0xAA.
- Drain 16 words: rdata sequence 0x00..0x0F, each one cycle after ren, with rvalid pulsing once per read. A 17th read gives underflow=1 and rvalid=0. clr_err clears both error flags.
- Wrap: write/read 40 words streaming with wen=ren=1 continuously after one pre-load. Data stays in order across pointer wrap and count holds at 1.
- Simultaneous: wen=ren=1 when full gives read accepted, write rejected, count=15, overflow=1. wen=ren=1 when empty gives write accepted, read rejected, count=1, underflow=1.
- flush with count=9 and wen=1 in the same cycle: next cycle count=0, empty=1, and the write is dropped. Under SYNC_FIFO_PARITY_EN, forcing a stored parity bit flip gives parity_err=1 with that word's rvalid.
